// File: rtl/rvr_lsu_pkg.sv
// Shared definitions for the Rover load/store unit: lsuop field layout,
// access size codes and the access FSM state encoding.
package rvr_lsu_pkg;

    // lsuop field positions
    localparam int OP_SIZE_LO = 0;
    localparam int OP_SIZE_HI = 1;
    localparam int OP_UNS     = 2;
    localparam int OP_STORE   = 3;

    // Access size codes (lsuop[1:0])
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Access FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/rvr_lsu_lane.sv
// Byte-lane steering for one access beat. The access is viewed as a
// window two bus words wide: beat 0 is the low word, beat 1 the high word.
// Stores shift data/strobes up by the byte offset; loads shift the merged
// pair of beats down by the offset and then sign/zero-extend.
module rvr_lsu_lane #(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] off,
    input  logic [1:0]                  size,
    input  logic                        uns,
    input  logic                        beat,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W-1:0]           hold,
    input  logic [DATA_W-1:0]           bus_rdata,
    output logic [DATA_W/8-1:0]         strb,
    output logic [DATA_W-1:0]           lane_wdata,
    output logic [DATA_W-1:0]           load_data
);

    localparam int BYTES = DATA_W / 8;

    logic [2*BYTES-1:0]  base_m;
    logic [2*BYTES-1:0]  wide_m;
    logic [2*DATA_W-1:0] wide_w;
    logic [2*DATA_W-1:0] wide_r;
    logic [DATA_W-1:0]   aligned;
    logic                sign_bit;
    int                  nbits;

    // Store side: place strobes and data at the byte offset, pick the beat half
    always_comb begin
        base_m = '0;
        for (int i = 0; i < 2*BYTES; i++) begin
            if (i < (1 << size)) base_m[i] = 1'b1;
        end
        wide_m     = base_m << off;
        wide_w     = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
        strb       = beat ? wide_m[2*BYTES-1:BYTES] : wide_m[BYTES-1:0];
        lane_wdata = beat ? wide_w[2*DATA_W-1:DATA_W] : wide_w[DATA_W-1:0];
    end

    // Load side: beat 1 stacks the bus word above the held beat-0 word
    always_comb begin
        wide_r   = beat ? {bus_rdata, hold} : {{DATA_W{1'b0}}, bus_rdata};
        aligned  = DATA_W'(wide_r >> {off, 3'b000});
        nbits    = 8 << size;
        if (nbits > DATA_W) nbits = DATA_W;
        sign_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == nbits - 1) sign_bit = aligned[i];
        end
        for (int i = 0; i < DATA_W; i++) begin
            load_data[i] = (i < nbits) ? aligned[i] : (sign_bit & ~uns);
        end
    end

endmodule

// File: rtl/rvr_lsu_split.sv
// Load/store unit: turns one B/H/W/D access into one or two aligned bus
// beats, merges and extends load data, and reports access faults.
// Handshake: mem_valid rises in BEAT0/BEAT1 and stays high with stable
// mem_addr/mem_wdata/mem_wstrb until a cycle where mem_ready=1 completes the
// beat; mem_err/mem_rdata are only looked at in that cycle. Upstream, req is
// taken only in IDLE and ready pulses for one cycle with rdata/err valid.
module rvr_lsu_split
    import rvr_lsu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SPLIT_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [3:0]          lsuop,
    output logic                ready,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic                mem_valid,
    input  logic                mem_ready,
    input  logic                mem_err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    output lsu_state_e          dbg_state
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    lsu_state_e         state_q, state_d;
    logic [DATA_W-1:0]  hold_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

    logic [OFF_W-1:0]   off;
    logic [1:0]         size;
    logic               is_store;
    logic               misaligned;
    logic               illegal;
    logic               bad;
    logic               in_beat1;
    logic [ADDR_W-1:0]  base_addr;
    logic [BYTES-1:0]   lane_strb;
    logic [DATA_W-1:0]  lane_wdata;
    logic [DATA_W-1:0]  load_data;

    assign off        = addr[OFF_W-1:0];
    assign size       = lsuop[OP_SIZE_HI:OP_SIZE_LO];
    assign is_store   = lsuop[OP_STORE];
    assign misaligned = (int'(off) + (1 << size)) > BYTES;
    assign illegal    = (size == SZ_D) && (DATA_W != 64);
    assign bad        = illegal || (misaligned && (SPLIT_EN == 0));
    assign in_beat1   = (state_q == ST_BEAT1);
    assign base_addr  = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign dbg_state  = state_q;

    rvr_lsu_lane #(.DATA_W(DATA_W)) u_lane (
        .off        (off),
        .size       (size),
        .uns        (lsuop[OP_UNS]),
        .beat       (in_beat1),
        .wdata      (wdata),
        .hold       (hold_q),
        .bus_rdata  (mem_rdata),
        .strb       (lane_strb),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    // State register; reset aborts any beat in flight
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and bus/handshake outputs
    always_comb begin
        state_d   = state_q;
        mem_valid = 1'b0;
        ready     = 1'b0;
        err       = 1'b0;
        mem_addr  = base_addr;
        mem_wdata = lane_wdata;
        mem_wstrb = '0;
        case (state_q)
            ST_IDLE: begin
                if (req) state_d = bad ? ST_DONE : ST_BEAT0;
            end
            ST_BEAT0: begin
                mem_valid = 1'b1;
                mem_wstrb = is_store ? lane_strb : '0;
                if (mem_ready) state_d = (mem_err || !misaligned) ? ST_DONE : ST_BEAT1;
            end
            ST_BEAT1: begin
                mem_valid = 1'b1;
                mem_addr  = base_addr + ADDR_W'(BYTES);
                mem_wstrb = is_store ? lane_strb : '0;
                if (mem_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                ready   = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rdata = rdata_q;

    // Beat-0 holding register, load result and fault flag
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        err_q <= bad;
                        if (bad) rdata_q <= '0;
                    end
                end
                ST_BEAT0: begin
                    if (mem_ready) begin
                        hold_q <= mem_rdata;
                        if (mem_err) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else if (!misaligned) begin
                            err_q   <= 1'b0;
                            rdata_q <= is_store ? '0 : load_data;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (mem_ready) begin
                        err_q   <= mem_err;
                        rdata_q <= (is_store || mem_err) ? '0 : load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rvr_lsu_split.sv
// Bench for rvr_lsu_split: a table of directed 32-bit accesses with a
// bus responder, plus hand sequences for reset abort, split-disabled and
// the 64-bit configuration.
module tb_rvr_lsu_split;
    import rvr_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit, split enabled
    logic        req = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata, mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  lsuop = '0, mem_wstrb;
    logic        ready, err, mem_valid, mem_ready = 1'b0, mem_err = 1'b0;
    lsu_state_e  dbg32;

    // 32-bit, split disabled
    logic        req_n = 1'b0;
    logic [31:0] addr_n = '0, wdata_n = '0, rdata_n, maddr_n, mwdata_n, mrdata_n = '0;
    logic [3:0]  lsuop_n = '0, mwstrb_n;
    logic        ready_n, err_n, mvalid_n, mready_n = 1'b0, merr_n = 1'b0;
    lsu_state_e  dbg_n;

    // 64-bit
    logic        req6 = 1'b0;
    logic [31:0] addr6 = '0, maddr6;
    logic [63:0] wdata6 = '0, rdata6, mwdata6, mrdata6 = '0;
    logic [3:0]  lsuop6 = '0;
    logic [7:0]  mwstrb6;
    logic        ready6, err6, mvalid6, mready6 = 1'b0, merr6 = 1'b0;
    lsu_state_e  dbg6;

    rvr_lsu_split #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata), .lsuop(lsuop),
        .ready(ready), .rdata(rdata), .err(err), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_err(mem_err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .dbg_state(dbg32));

    rvr_lsu_split #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(0)) dut_nosplit (
        .clk(clk), .rst(rst), .req(req_n), .addr(addr_n), .wdata(wdata_n), .lsuop(lsuop_n),
        .ready(ready_n), .rdata(rdata_n), .err(err_n), .mem_valid(mvalid_n),
        .mem_ready(mready_n), .mem_err(merr_n), .mem_addr(maddr_n),
        .mem_wdata(mwdata_n), .mem_wstrb(mwstrb_n), .mem_rdata(mrdata_n),
        .dbg_state(dbg_n));

    rvr_lsu_split #(.DATA_W(64), .ADDR_W(32), .SPLIT_EN(1)) dut64 (
        .clk(clk), .rst(rst), .req(req6), .addr(addr6), .wdata(wdata6), .lsuop(lsuop6),
        .ready(ready6), .rdata(rdata6), .err(err6), .mem_valid(mvalid6),
        .mem_ready(mready6), .mem_err(merr6), .mem_addr(maddr6),
        .mem_wdata(mwdata6), .mem_wstrb(mwstrb6), .mem_rdata(mrdata6),
        .dbg_state(dbg6));

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  op;
        logic [31:0] wdata;
        logic [31:0] rd0, rd1;
        int          waits;     // mem_ready=0 cycles before each beat completes
        int          err_beat;  // 0 none, 1 beat0, 2 beat1
        int          nbeats;
        logic [31:0] a0, a1;
        logic [3:0]  s0, s1;
        logic [31:0] w0, w1;    // expected store data under the expected strobes
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;   // cycles from req to ready
    } vec_t;

    localparam int NVEC = 14;
    vec_t        vecs[NVEC];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        lane_mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // Drive one access on the 32-bit split unit and act as the bus slave
    task automatic run_vec(input vec_t v, input int idx);
        int          beat, wcnt, lat;
        bit          done;
        logic [31:0] cur_a;
        logic [3:0]  cur_s;
        logic [31:0] cur_w;
        exp_q.delete();
        if (v.nbeats > 0) exp_q.push_back(v.a0);
        if (v.nbeats > 1) exp_q.push_back(v.a1);
        @(posedge clk); #1;
        req = 1'b1; addr = v.addr; lsuop = v.op; wdata = v.wdata;
        beat = 0; wcnt = 0; done = 1'b0; lat = 0; cur_a = '0;
        for (int k = 1; k <= 30 && !done; k++) begin
            @(posedge clk); #1;
            req = 1'b0; mem_ready = 1'b0; mem_err = 1'b0;
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
                lat  = k;
                chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
                chk($sformatf("v%0d err", idx), 64'(err), 64'(v.exp_err));
                if (!v.exp_err) chk($sformatf("v%0d rdata", idx), 64'(rdata), 64'(v.exp_rdata));
            end else if (mem_valid) begin
                if (wcnt == 0) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("v%0d unexpected beat", idx), 64'(beat), 64'(v.nbeats));
                        cur_a = mem_addr;
                    end else begin
                        cur_a = exp_q.pop_front();
                    end
                end
                cur_s = (beat == 0) ? v.s0 : v.s1;
                cur_w = (beat == 0) ? v.w0 : v.w1;
                chk($sformatf("v%0d b%0d mem_addr", idx, beat), 64'(mem_addr), 64'(cur_a));
                chk($sformatf("v%0d b%0d wstrb", idx, beat), 64'(mem_wstrb), 64'(cur_s));
                chk($sformatf("v%0d b%0d wdata", idx, beat), 64'(mem_wdata & lane_mask(cur_s)), 64'(cur_w));
                if (wcnt == v.waits) begin
                    mem_ready = 1'b1;
                    mem_err   = (v.err_beat == beat + 1);
                    mem_rdata = (beat == 0) ? v.rd0 : v.rd1;
                    beat++;
                    wcnt = 0;
                end else begin
                    mem_rdata = $urandom;
                    wcnt++;
                end
            end
        end
        if (!done) chk($sformatf("v%0d ready timeout", idx), 64'(0), 64'(1));
        chk($sformatf("v%0d beats issued", idx), 64'(beat), 64'(v.nbeats));
    endtask

    initial begin
        int  lat;
        bit  seen;
        int  b6;
        logic [31:0] a6;

        //            addr          op       wdata         rd0           rd1           w  e  n  a0            a1            s0       s1       w0            w1            exp_rdata     er    lat
        vecs[0]  = '{32'h0000_1000, 4'b0010, 32'h0,        32'hDEADBEEF, 32'h0,        0, 0, 1, 32'h0000_1000, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'hDEADBEEF, 1'b0, 2};
        vecs[1]  = '{32'h0000_1003, 4'b0001, 32'h0,        32'h80000000, 32'h000000FF, 0, 0, 2, 32'h0000_1000, 32'h0000_1004, 4'b0000, 4'b0000, 32'h0,        32'h0,        32'hFFFFFF80, 1'b0, 3};
        vecs[2]  = '{32'h0000_1003, 4'b0101, 32'h0,        32'h80000000, 32'h000000FF, 0, 0, 2, 32'h0000_1000, 32'h0000_1004, 4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0000FF80, 1'b0, 3};
        vecs[3]  = '{32'h0000_1002, 4'b1010, 32'h11223344, 32'h0,        32'h0,        0, 0, 2, 32'h0000_1000, 32'h0000_1004, 4'b1100, 4'b0011, 32'h33440000, 32'h00001122, 32'h0,        1'b0, 3};
        vecs[4]  = '{32'hFFFF_FFFE, 4'b0010, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0, 0, 2, 32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 4'b0000, 32'h0,        32'h0,        32'hDEF01234, 1'b0, 3};
        vecs[5]  = '{32'h0000_1001, 4'b0000, 32'h0,        32'h00008000, 32'h0,        0, 0, 1, 32'h0000_1000, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'hFFFFFF80, 1'b0, 2};
        vecs[6]  = '{32'h0000_1001, 4'b0100, 32'h0,        32'h00008000, 32'h0,        0, 0, 1, 32'h0000_1000, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h00000080, 1'b0, 2};
        vecs[7]  = '{32'h0000_1003, 4'b1000, 32'h000000AB, 32'h0,        32'h0,        0, 0, 1, 32'h0000_1000, 32'h0,        4'b1000, 4'b0000, 32'hAB000000, 32'h0,        32'h0,        1'b0, 2};
        vecs[8]  = '{32'h0000_1002, 4'b1001, 32'h0000BEEF, 32'h0,        32'h0,        0, 0, 1, 32'h0000_1000, 32'h0,        4'b1100, 4'b0000, 32'hBEEF0000, 32'h0,        32'h0,        1'b0, 2};
        vecs[9]  = '{32'h0000_1000, 4'b0011, 32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1};
        vecs[10] = '{32'h0000_2000, 4'b0010, 32'h0,        32'h01020304, 32'h0,        2, 0, 1, 32'h0000_2000, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h01020304, 1'b0, 4};
        vecs[11] = '{32'h0000_1002, 4'b0001, 32'h0,        32'h7FFF0000, 32'h0,        0, 0, 1, 32'h0000_1000, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h00007FFF, 1'b0, 2};
        vecs[12] = '{32'h0000_1001, 4'b0010, 32'h0,        32'h55555555, 32'h0,        0, 1, 1, 32'h0000_1000, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 2};
        vecs[13] = '{32'h0000_1002, 4'b1010, 32'h11223344, 32'h0,        32'h0,        3, 2, 2, 32'h0000_1000, 32'h0000_1004, 4'b1100, 4'b0011, 32'h33440000, 32'h00001122, 32'h0,        1'b1, 9};

        // Reset values while reset is held
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset mem_valid", 64'(mem_valid), 64'(0));
        chk("reset ready", 64'(ready), 64'(0));
        chk("reset err", 64'(err), 64'(0));
        chk("reset mem_wstrb", 64'(mem_wstrb), 64'(0));
        chk("reset rdata", 64'(rdata), 64'(0));
        chk("reset rdata64", rdata6, 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Table of directed accesses, issued back to back
        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // Reset while a split store waits in BEAT0
        @(posedge clk); #1;
        req = 1'b1; addr = 32'h0000_1002; lsuop = 4'b1010; wdata = 32'h11223344;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("abort in beat0 mem_valid", 64'(mem_valid), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort mem_valid after rst", 64'(mem_valid), 64'(0));
        // Stray mem_ready while idle must not start or complete anything
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("abort no ready c%0d", k), 64'(ready), 64'(0));
            chk($sformatf("abort idle mem_valid c%0d", k), 64'(mem_valid), 64'(0));
        end
        mem_ready = 1'b0;

        // Split disabled: misaligned word faults with no bus activity
        @(posedge clk); #1;
        req_n = 1'b1; addr_n = 32'hFFFF_FFFE; lsuop_n = 4'b0010;
        seen = 1'b0; lat = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(posedge clk); #1;
            req_n = 1'b0;
            @(negedge clk);
            if (mvalid_n) seen = 1'b1;
            if (ready_n) begin
                lat = k;
                chk("nosplit err", 64'(err_n), 64'(1));
            end
        end
        chk("nosplit latency", 64'(lat), 64'(1));
        chk("nosplit bus idle", 64'(seen), 64'(0));

        // 64-bit: LD at 0x2004 splits across two dwords
        exp_q.delete();
        exp_q.push_back(32'h0000_2000);
        exp_q.push_back(32'h0000_2008);
        @(posedge clk); #1;
        req6 = 1'b1; addr6 = 32'h0000_2004; lsuop6 = 4'b0011;
        lat = 0; b6 = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(posedge clk); #1;
            req6 = 1'b0; mready6 = 1'b0;
            @(negedge clk);
            if (ready6) begin
                lat = k;
                chk("ld64 err", 64'(err6), 64'(0));
                chk("ld64 rdata", rdata6, 64'hDDEEFF00_11223344);
            end else if (mvalid6) begin
                a6 = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                chk($sformatf("ld64 b%0d mem_addr", b6), 64'(maddr6), 64'(a6));
                chk($sformatf("ld64 b%0d wstrb", b6), 64'(mwstrb6), 64'(0));
                mready6 = 1'b1;
                mrdata6 = (b6 == 0) ? 64'h11223344_55667788 : 64'h99AABBCC_DDEEFF00;
                b6++;
            end
        end
        chk("ld64 latency", 64'(lat), 64'(3));
        chk("ld64 beats", 64'(b6), 64'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvr_lsu_split.md
# rvr_lsu_split

Parametrised load/store unit for the Rover core. Sits between the execute stage and the data-memory port; converts one byte/half/word/(dword) access request into one or two aligned memory transactions over a valid/ready bus. Splits misaligned accesses into two beats, merges and sign/zero-extends load data, and reports bus and alignment errors. Successor to the fixed 32-bit, aligned-only LSU.

## Interface
- Reset: one clock; reset is synchronous and active-high.
- DATA_W, 32: memory/register data width, 32 or 64; BYTES = DATA_W/8.
- ADDR_W, 32: address width.
- SPLIT_EN, 1: 1 = split misaligned accesses; 0 = flag misaligned accesses as errors without bus activity.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  1  access request; sampled only in IDLE; addr/wdata/lsuop held stable until ready.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  store data, right-justified.
- lsuop  in  4  [1:0] size (00 B, 01 H, 10 W, 11 D; D legal only when DATA_W=64), [2] unsigned load, [3] store.
- ready  out  1  one-cycle completion pulse; rdata/err valid in the same cycle.
- rdata  out  DATA_W  registered, extended load result; 0 for stores.
- err  out  1  access faulted (misaligned with SPLIT_EN=0, illegal size, or mem_err).
- mem_valid  out  1  bus request; held until mem_ready.
- mem_ready  in  1  bus beat complete.
- mem_err  in  1  bus fault, qualified by mem_ready.
- mem_addr  out  ADDR_W  BYTES-aligned beat address.
- mem_wdata  out  DATA_W  lane-shifted store data.
- mem_wstrb  out  BYTES  byte strobes; all zero for loads.
- mem_rdata  in  DATA_W  load data, valid with mem_ready.

## Operation
- off = addr mod BYTES; n = 1<<size; misaligned when off+n > BYTES (two-beat access).
- Beat 0: mem_addr = addr with low bits cleared; store lanes off..min(off+n,BYTES)-1.
- Beat 1: mem_addr = beat0 address + BYTES, wraps modulo 2^ADDR_W; store lanes 0..off+n-BYTES-1 carry the upper bytes.
- Loads: beat-0 bytes captured into a BYTES-wide holding register; beat-1 bytes concatenated above; result extended from bit 8n-1 (sign unless lsuop[2]).
- Illegal size (11 with DATA_W=32), or misaligned with SPLIT_EN=0: no bus beat, go straight to DONE with err=1.
- FSM states: IDLE, BEAT0, BEAT1, DONE.
  - IDLE: req → BEAT0 (legal) or DONE (error).
  - BEAT0: mem_valid=1; on mem_ready: mem_err → DONE err=1; split → BEAT1; else → DONE.
  - BEAT1: mem_valid=1; on mem_ready → DONE, err=mem_err.
  - DONE: ready=1 for one cycle → IDLE.
- Store split, beat-1 fault: beat-0 bytes stay written; err=1. No rollback.
- mem_addr/mem_wdata/mem_wstrb stable while mem_valid=1.

## Timing
- Reset values: state IDLE; mem_valid, ready, err, mem_wstrb = 0; rdata, holding register = 0.
- Zero-wait bus, aligned: req at cycle N → mem_valid N+1 → ready N+2. Split: ready N+3. Error without bus: ready N+1.
- Wait states extend BEAT0/BEAT1 one cycle per cycle of mem_ready=0.
- req high in the IDLE cycle after DONE starts a new access; back-to-back accesses are legal.
- rst during BEAT0/BEAT1: abort in the same edge, mem_valid=0 next cycle, no ready pulse.
- mem_ready while mem_valid=0 is ignored.

## Structure
- Shared package rvr_lsu_pkg: lsuop field positions, size codes, FSM state encoding.
- Sub-module rvr_lsu_lane (combinational): given off, size, beat index → strobes, store-lane shift, load byte select. Instantiated once; the top holds the FSM and registers.

## Test plan
- DATA_W=32, LW 0x1000, mem_rdata 0xDEADBEEF, zero wait → one beat at 0x1000, wstrb 0000, ready at N+2, rdata 0xDEADBEEF.
- LH signed at 0x1003: beat0 0x1000 rdata 0x80000000, beat1 0x1004 rdata 0x000000FF → rdata 0xFFFFFF80; LHU same → 0x0000FF80.
- SW at 0x1002, wdata 0x11223344: beat0 0x1000 wstrb 1100 wdata[31:16]=0x3344; beat1 0x1004 wstrb 0011 wdata[15:0]=0x1122.
- LW at 0xFFFFFFFE: beat1 mem_addr 0x00000000; SPLIT_EN=0 same request → no mem_valid, ready at N+1, err=1.
- SW split with mem_err on beat1 and three wait states each beat → err=1, ready one cycle after beat1 mem_ready; rst asserted mid-BEAT0 → mem_valid 0 next cycle, no ready.
- DATA_W=64, LD at 0x2004 → beats 0x2000/0x2008, result bytes = beat0[63:32], beat1[31:0]; LD with DATA_W=32 → err=1, no bus activity.
